// File: rtl/inst_dec_pkg.sv
// Shared decode constants, field positions and types for the CAE dispatch decoder.
package inst_dec_pkg;

    localparam int AEG_IDX_W = 18;
    localparam int CAEP_W    = 5;

    // Instruction field bit positions
    localparam int OP_MSB   = 28;
    localparam int OP_LSB   = 24;
    localparam int CAEP_MSB = 22;
    localparam int CAEP_LSB = 18;
    localparam int IDX_MSB  = 17;
    localparam int IDX_LSB  = 0;

    // Opcodes handled by the decoder
    localparam logic [4:0] OP_AEG_WR_IMM = 5'h0D;
    localparam logic [4:0] OP_AEG_RD_IMM = 5'h0E;
    localparam logic [4:0] OP_AEG_RD_IND = 5'h10;
    // op[4:3] pattern marking a custom CAEP instruction (0x18..0x1F)
    localparam logic [1:0] CAEP_CLASS    = 2'b11;

    typedef enum logic [2:0] {
        CLS_CUSTOM     = 3'd0,
        CLS_AEG_WR     = 3'd1,
        CLS_AEG_RD_IMM = 3'd2,
        CLS_AEG_RD_IND = 3'd3,
        CLS_UNIMPL     = 3'd4
    } inst_cls_e;

    // Registered decode result
    typedef struct packed {
        logic                 val;
        logic [CAEP_W-1:0]    caep;
        logic                 aeg_wr;
        logic                 aeg_rd;
        logic [AEG_IDX_W-1:0] aeg_idx;
        logic [63:0]          data;
        logic                 unimpl;
    } dec_t;

    // Map an opcode to its instruction class
    function automatic inst_cls_e classify(input logic [4:0] op);
        inst_cls_e cls;
        if (op[4:3] == CAEP_CLASS)        cls = CLS_CUSTOM;
        else if (op == OP_AEG_WR_IMM)     cls = CLS_AEG_WR;
        else if (op == OP_AEG_RD_IMM)     cls = CLS_AEG_RD_IMM;
        else if (op == OP_AEG_RD_IND)     cls = CLS_AEG_RD_IND;
        else                              cls = CLS_UNIMPL;
        return cls;
    endfunction

endpackage

// File: rtl/inst_dec_if.sv
// Dispatch-side instruction inputs and decoded outputs of inst_dec.
// Handshake: cae_inst_vld qualifies cae_inst/cae_data for exactly one cycle;
// there is no ready, the decoder accepts every valid cycle. Each output strobe
// is a one-cycle pulse that qualifies inst_caep/inst_aeg_idx/inst_data.
interface inst_dec_if;
    import inst_dec_pkg::*;

    logic [31:0]          cae_inst;
    logic [63:0]          cae_data;
    logic                 cae_inst_vld;
    logic                 inst_val;
    logic [CAEP_W-1:0]    inst_caep;
    logic                 inst_aeg_wr;
    logic                 inst_aeg_rd;
    logic [AEG_IDX_W-1:0] inst_aeg_idx;
    logic [63:0]          inst_data;
    logic                 err_unimpl;

    // Dispatch side: drives instructions, observes decode
    modport master (
        output cae_inst, cae_data, cae_inst_vld,
        input  inst_val, inst_caep, inst_aeg_wr, inst_aeg_rd,
               inst_aeg_idx, inst_data, err_unimpl
    );

    // Decoder side
    modport slave (
        input  cae_inst, cae_data, cae_inst_vld,
        output inst_val, inst_caep, inst_aeg_wr, inst_aeg_rd,
               inst_aeg_idx, inst_data, err_unimpl
    );

endinterface

// File: rtl/inst_dec.sv
// CAE instruction decoder: classifies a dispatched instruction into custom
// CAEP, AEG write, AEG read or unimplemented, with one registered stage.
// No range checks are made on the AEG index or CAEP number; the consumer owns that.
module inst_dec
    import inst_dec_pkg::*;
(
    input  logic       clk,
    input  logic       i_reset,
    inst_dec_if.slave  dif
);

    dec_t      dec_nxt;
    dec_t      dec_q;
    inst_cls_e cls;

    assign cls = classify(dif.cae_inst[OP_MSB:OP_LSB]);

    // Combinational classify; everything stays zero when no instruction is valid
    always_comb begin
        dec_nxt = '0;
        if (dif.cae_inst_vld) begin
            dec_nxt.data = dif.cae_data;
            case (cls)
                CLS_CUSTOM: begin
                    dec_nxt.val  = 1'b1;
                    dec_nxt.caep = dif.cae_inst[CAEP_MSB:CAEP_LSB];
                end
                CLS_AEG_WR: begin
                    dec_nxt.aeg_wr  = 1'b1;
                    dec_nxt.aeg_idx = dif.cae_inst[IDX_MSB:IDX_LSB];
                end
                CLS_AEG_RD_IMM: begin
                    dec_nxt.aeg_rd  = 1'b1;
                    dec_nxt.aeg_idx = dif.cae_inst[IDX_MSB:IDX_LSB];
                end
                CLS_AEG_RD_IND: begin
                    dec_nxt.aeg_rd  = 1'b1;
                    dec_nxt.aeg_idx = dif.cae_data[AEG_IDX_W-1:0];
                end
                default: begin
                    dec_nxt.unimpl = 1'b1;
                end
            endcase
        end
    end

    // Single output register; reset clears any in-flight decode at once
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_nxt;
        end
    end

    assign dif.inst_val     = dec_q.val;
    assign dif.inst_caep    = dec_q.caep;
    assign dif.inst_aeg_wr  = dec_q.aeg_wr;
    assign dif.inst_aeg_rd  = dec_q.aeg_rd;
    assign dif.inst_aeg_idx = dec_q.aeg_idx;
    assign dif.inst_data    = dec_q.data;
    assign dif.err_unimpl   = dec_q.unimpl;

endmodule

// File: tb/tb_inst_dec.sv
// Directed self-checking bench for inst_dec.
module tb_inst_dec;
    import inst_dec_pkg::*;

    // Strobe vector order: {inst_val, inst_aeg_wr, inst_aeg_rd, err_unimpl}
    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_VAL  = 4'b1000;
    localparam logic [3:0] S_WR   = 4'b0100;
    localparam logic [3:0] S_RD   = 4'b0010;
    localparam logic [3:0] S_ERR  = 4'b0001;

    logic clk;
    logic i_reset;
    int   n_cmp;
    int   n_err;
    logic [3:0] exp_q[$];

    inst_dec_if dif();

    inst_dec u_dut (
        .clk     (clk),
        .i_reset (i_reset),
        .dif     (dif)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [2:0] top, input logic [4:0] op,
                                            input logic [4:0] caep, input logic [17:0] idx);
        return {top, op, 1'b0, caep, idx};
    endfunction

    function automatic logic [3:0] strobes();
        return {dif.inst_val, dif.inst_aeg_wr, dif.inst_aeg_rd, dif.err_unimpl};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drivers: inputs change on the falling edge
    task automatic drive(input logic [31:0] inst, input logic [63:0] data, input logic vld);
        @(negedge clk);
        dif.cae_inst     = inst;
        dif.cae_data     = data;
        dif.cae_inst_vld = vld;
    endtask

    // Advance past the next rising edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_strb"}, {60'd0, strobes()}, {60'd0, S_NONE});
        check({tag, "_caep"}, {59'd0, dif.inst_caep}, 64'd0);
        check({tag, "_idx"},  {46'd0, dif.inst_aeg_idx}, 64'd0);
        check({tag, "_data"}, dif.inst_data, 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        i_reset          = 1'b1;
        dif.cae_inst     = '0;
        dif.cae_data     = '0;
        dif.cae_inst_vld = 1'b0;

        // Reset holds everything at zero even with a valid write presented
        drive(mk_inst(3'b000, 5'h0D, 5'd0, 18'h00001), 64'hDEADBEEF_01234567, 1'b1);
        step();
        check_zero("rst_hold");
        drive('0, '0, 1'b0);
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_zero("idle");
        end

        // AEG write, immediate index
        drive(mk_inst(3'b000, 5'h0D, 5'd0, 18'h00001), 64'hDEADBEEF_01234567, 1'b1);
        step();
        check("wr_strb", {60'd0, strobes()}, {60'd0, S_WR});
        check("wr_idx",  {46'd0, dif.inst_aeg_idx}, 64'd1);
        check("wr_data", dif.inst_data, 64'hDEADBEEF_01234567);
        drive('0, '0, 1'b0);
        step();
        check_zero("wr_after");

        // AEG read, immediate index; top bits set to show they are ignored
        drive(mk_inst(3'b111, 5'h0E, 5'd0, 18'd50), 64'h1111_2222_3333_4444, 1'b1);
        step();
        check("rdi_strb", {60'd0, strobes()}, {60'd0, S_RD});
        check("rdi_idx",  {46'd0, dif.inst_aeg_idx}, 64'd50);
        check("rdi_data", dif.inst_data, 64'h1111_2222_3333_4444);

        // AEG read, indirect index taken from the operand, no range check
        drive(mk_inst(3'b000, 5'h10, 5'd0, 18'h00005), 64'hABCD_0000_0003_FFFF, 1'b1);
        step();
        check("rdn_strb", {60'd0, strobes()}, {60'd0, S_RD});
        check("rdn_idx",  {46'd0, dif.inst_aeg_idx}, 64'h3FFFF);
        check("rdn_data", dif.inst_data, 64'hABCD_0000_0003_FFFF);

        // Custom instructions at both ends of the CAEP class
        drive(mk_inst(3'b000, 5'h18, 5'd0, 18'h2AAAA), 64'h5, 1'b1);
        step();
        check("c18_strb", {60'd0, strobes()}, {60'd0, S_VAL});
        check("c18_caep", {59'd0, dif.inst_caep}, 64'd0);
        drive(mk_inst(3'b010, 5'h1F, 5'd31, 18'h00000), 64'h6, 1'b1);
        step();
        check("c1f_strb", {60'd0, strobes()}, {60'd0, S_VAL});
        check("c1f_caep", {59'd0, dif.inst_caep}, 64'd31);
        check("c1f_data", dif.inst_data, 64'h6);

        // Unimplemented opcodes, valid then not valid
        drive(mk_inst(3'b000, 5'h00, 5'd3, 18'd9), 64'h77, 1'b1);
        step();
        check("u00_strb", {60'd0, strobes()}, {60'd0, S_ERR});
        check("u00_data", dif.inst_data, 64'h77);
        drive(mk_inst(3'b000, 5'h11, 5'd3, 18'd9), 64'h88, 1'b1);
        step();
        check("u11_strb", {60'd0, strobes()}, {60'd0, S_ERR});
        drive(mk_inst(3'b000, 5'h00, 5'd3, 18'd9), 64'h77, 1'b0);
        step();
        check_zero("u00_novld");
        drive(mk_inst(3'b000, 5'h11, 5'd3, 18'd9), 64'h88, 1'b0);
        step();
        check_zero("u11_novld");

        // Back-to-back stream: write, read, custom, unimplemented
        exp_q.push_back(S_WR);
        exp_q.push_back(S_RD);
        exp_q.push_back(S_VAL);
        exp_q.push_back(S_ERR);
        drive(mk_inst(3'b000, 5'h0D, 5'd0, 18'd7), 64'hA, 1'b1);
        step();
        check("s0_strb", {60'd0, strobes()}, {60'd0, exp_q.pop_front()});
        check("s0_idx",  {46'd0, dif.inst_aeg_idx}, 64'd7);
        drive(mk_inst(3'b000, 5'h0E, 5'd0, 18'd8), 64'hB, 1'b1);
        step();
        check("s1_strb", {60'd0, strobes()}, {60'd0, exp_q.pop_front()});
        check("s1_idx",  {46'd0, dif.inst_aeg_idx}, 64'd8);
        drive(mk_inst(3'b000, 5'h1A, 5'd12, 18'd0), 64'hC, 1'b1);
        step();
        check("s2_strb", {60'd0, strobes()}, {60'd0, exp_q.pop_front()});
        check("s2_caep", {59'd0, dif.inst_caep}, 64'd12);
        drive(mk_inst(3'b000, 5'h0F, 5'd0, 18'd0), 64'hD, 1'b1);
        step();
        check("s3_strb", {60'd0, strobes()}, {60'd0, exp_q.pop_front()});
        check("s3_data", dif.inst_data, 64'hD);

        // Mid-stream asynchronous reset: a custom pulse is visible, then reset kills it before the next edge
        drive(mk_inst(3'b000, 5'h1C, 5'd4, 18'd0), 64'hE, 1'b1);
        step();
        check("pre_rst_strb", {60'd0, strobes()}, {60'd0, S_VAL});
        #2;
        i_reset = 1'b1;
        #1;
        check_zero("async_rst");
        drive(mk_inst(3'b000, 5'h0D, 5'd0, 18'd3), 64'hF, 1'b1);
        step();
        check_zero("rst_inflight");
        drive('0, '0, 1'b0);
        i_reset = 1'b0;
        step();
        check_zero("post_rst");

        // Decode resumes after reset
        drive(mk_inst(3'b000, 5'h0D, 5'd0, 18'd3), 64'hF, 1'b1);
        step();
        check("resume_strb", {60'd0, strobes()}, {60'd0, S_WR});
        check("resume_idx",  {46'd0, dif.inst_aeg_idx}, 64'd3);
        drive('0, '0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
